sdram_frame_arbiter: RTL and testbench
======================================

# sdram_frame_arbiter

Schedules the single SDRAM port between the camera write path and the VGA read path. It watches the fill levels of the camera-side and VGA-side async FIFOs and issues fixed-length burst commands to the SDRAM command engine. It maintains double-buffered frame addresses so that a displayed frame is never the one being written. It sits in the 100 MHz SDRAM clock domain, between the two FIFOs and the burst engine.

## Interface
- BURST_LEN, 256: words per burst command. Power of two, ≤ 512.
- FRAME_WORDS, 307200: 16-bit words per frame (640×480). Must be a multiple of BURST_LEN.
- BUF1_BASE, 24'h080000: word address of frame buffer 1. Buffer 0 is at 0.
- ADDR_W, 24: SDRAM word address width (bank + row + column).
- clk, input, 1: SDRAM-domain clock; all logic is on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- wr_count, input, 10: camera FIFO read-side fill count.
- rd_count, input, 10: VGA FIFO write-side fill count.
- wr_frame_start, input, 1: one-cycle pulse, camera vsync (already synchronized).
- rd_frame_start, input, 1: one-cycle pulse, VGA vsync (already synchronized).
- cmd_valid, output, 1: burst command valid.
- cmd_ready, input, 1: burst engine accepts the command.
- cmd_write, output, 1: 1 = write burst (FIFO→SDRAM), 0 = read burst.
- cmd_addr, output, ADDR_W: burst start word address.
- burst_done, input, 1: one-cycle pulse when the accepted burst has fully completed.
- wr_buf, output, 1: buffer currently being written.
- rd_buf, output, 1: buffer currently being displayed.
- busy, output, 1: high from command issue through burst_done.

## Operation
- FSM states: IDLE, REQ, WAIT_DONE.
- IDLE: evaluate requests and latch the winner into REQ.
  - Write request: wr_count ≥ BURST_LEN and the write frame is not complete.
  - Read request: rd_count ≤ 1023−BURST_LEN and the read frame is not complete.
- Arbitration priority: write wins (the camera cannot stall). If two consecutive writes were granted and a read is pending, the read wins the next arbitration. The consecutive-write counter clears on any read grant.
- REQ: drive cmd_valid with cmd_write and cmd_addr stable. On cmd_valid && cmd_ready, go to WAIT_DONE.
- WAIT_DONE: on burst_done, advance the granted pointer by BURST_LEN, then go to IDLE.
- Write pointer:
  - When wr_ptr reaches FRAME_WORDS, set wr_done and stop issuing writes.
  - On wr_frame_start: if wr_done, set last_full ← wr_buf and wr_buf ← ~wr_buf. In all cases clear wr_ptr and wr_done (a partial frame is abandoned).
- Read pointer:
  - Same rules as the write pointer, using rd_done.
  - On rd_frame_start: rd_buf ← last_full if a full frame exists, else rd_buf is unchanged. Clear rd_ptr and rd_done.
- cmd_addr = (buf ? BUF1_BASE : 0) + ptr.
- Frame-start pulses arriving during REQ or WAIT_DONE are held in a pending flag. They are applied in the cycle that burst_done returns the FSM to IDLE, after the pointer advance.
- Simultaneous wr_frame_start and rd_frame_start: apply the write swap first, so the read side sees the new last_full in the same cycle.
- Reset mid-burst: all state returns to reset values immediately. cmd_valid drops. Any burst_done arriving afterwards is ignored in IDLE.

## Timing
- Reset values:
  - cmd_valid 0, cmd_write 0, cmd_addr 0, busy 0.
  - wr_buf 0, rd_buf 1, last_full 0, full-frame-exists 0.
  - Both pointers 0, both done flags 0, FSM in IDLE.
- Issue latency: request true in IDLE → cmd_valid high on the next cycle.
- cmd_valid, cmd_write and cmd_addr stay constant until the handshake completes. cmd_valid never drops without cmd_ready.
- busy rises with cmd_valid and falls the cycle after burst_done.
- Minimum one IDLE cycle between bursts.
- The pointer update is visible in cmd_addr on the next issue.

## Structure
- Shared package sdram_pkg holds:
  - the FSM state encoding;
  - ADDR_W, BURST_LEN and FRAME_WORDS defaults;
  - the buffer-base constants, which are also used by the burst engine.
- One sub-module, frame_ptr: pointer counter, done flag and pending frame-start logic. It is instantiated twice, once for write and once for read.

## Test plan
- Write-only: wr_count=256 held, rd_count=1023 → writes at addresses 0, 256, 512… After 1200 bursts, wr_done is set and no further write is issued.
- Contention: wr_count=300 and rd_count=0 held → grant sequence W, W, R, W, W, R. The read addresses start at BUF1_BASE.
- Swap: complete a write frame, then pulse wr_frame_start → wr_buf=1. Then pulse rd_frame_start → rd_buf=0, and the next read address is 0.
- Frame start mid-burst: pulse wr_frame_start during WAIT_DONE → the pointer is cleared only after burst_done, and the next write address is the new buffer base.
- Partial frame: wr_frame_start at wr_ptr=1024 → no swap, wr_buf is unchanged, next write address is the current buffer base.
- Reset: deassert rst_n while cmd_valid=1 → all outputs reach reset values asynchronously. A burst_done pulsed after release does not move the pointers.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM scheduling definitions: arbiter FSM encoding, default geometry and buffer bases.
// The buffer-base constants are also consumed by the burst engine.
package sdram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitDone
    } arb_state_e;

    localparam int unsigned SDRAM_ADDR_W      = 24;
    localparam int unsigned SDRAM_BURST_LEN   = 256;
    localparam int unsigned SDRAM_FRAME_WORDS = 307200;

    localparam logic [23:0] SDRAM_BUF0_BASE = 24'h000000;
    localparam logic [23:0] SDRAM_BUF1_BASE = 24'h080000;

endpackage

// File: rtl/frame_ptr.sv
// Per-direction frame pointer: burst-granular word counter, frame-complete flag and a
// frame-start request that is held until the arbiter is back in (or returning to) idle.
module frame_ptr
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
    parameter int unsigned BURST_LEN   = SDRAM_BURST_LEN,
    parameter int unsigned FRAME_WORDS = SDRAM_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              apply,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              done,
    output logic              restart,
    output logic              swap
);

    localparam logic [ADDR_W-1:0] Step = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] Last = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_next;
    logic              done_q, done_d, pend_q, pend_d, done_after;

    always_comb begin
        ptr_next   = ptr_q + Step;
        // A start applied in the same cycle as the final burst must still see a full frame.
        done_after = done_q || (advance && (ptr_next == Last));
        restart    = apply && (start || pend_q);
        swap       = restart && done_after;

        ptr_d  = ptr_q;
        done_d = done_after;
        pend_d = pend_q;
        if (advance) begin
            ptr_d = ptr_next;
        end
        if (restart) begin
            ptr_d  = '0;
            done_d = 1'b0;
        end
        if (apply) begin
            pend_d = 1'b0;
        end else if (start) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            done_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            done_q <= done_d;
            pend_q <= pend_d;
        end
    end

    assign ptr  = ptr_q;
    assign done = done_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the SDRAM port between camera writes and VGA reads with fixed-length bursts,
// and double-buffers frames so the displayed buffer is never the one being written.
module sdram_frame_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned       BURST_LEN   = SDRAM_BURST_LEN,
    parameter int unsigned       FRAME_WORDS = SDRAM_FRAME_WORDS,
    parameter int unsigned       ADDR_W      = SDRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] BUF1_BASE   = SDRAM_BUF1_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        wr_count,
    input  logic [9:0]        rd_count,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic              wr_buf,
    output logic              rd_buf,
    output logic              busy
);

    localparam logic [10:0]       WrThresh = 11'(BURST_LEN);
    localparam logic [10:0]       RdThresh = 11'(1023 - BURST_LEN);
    localparam logic [ADDR_W-1:0] Buf0Base = ADDR_W'(SDRAM_BUF0_BASE);

    arb_state_e        state_q, state_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [1:0]        wr_run_q, wr_run_d;
    logic              wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic              last_full_q, last_full_d, have_full_q, have_full_d;
    logic              in_idle, done_now, apply, wr_req, rd_req, grant_rd;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_done, rd_done, wr_swap, rd_restart;
    logic              unused_wr_restart, unused_rd_swap;

    assign in_idle  = (state_q == StIdle);
    assign done_now = (state_q == StWaitDone) && burst_done;
    assign apply    = in_idle || done_now;
    assign wr_req   = ({1'b0, wr_count} >= WrThresh) && !wr_done;
    assign rd_req   = ({1'b0, rd_count} <= RdThresh) && !rd_done;
    // Writes win unless two writes in a row have already been granted.
    assign grant_rd = rd_req && (!wr_req || (wr_run_q == 2'd2));

    frame_ptr #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (wr_frame_start),
        .apply   (apply),
        .advance (done_now && cmd_write_q),
        .ptr     (wr_ptr),
        .done    (wr_done),
        .restart (unused_wr_restart),
        .swap    (wr_swap)
    );

    frame_ptr #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (rd_frame_start),
        .apply   (apply),
        .advance (done_now && !cmd_write_q),
        .ptr     (rd_ptr),
        .done    (rd_done),
        .restart (rd_restart),
        .swap    (unused_rd_swap)
    );

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        wr_run_d    = wr_run_q;
        unique case (state_q)
            StIdle: begin
                // A frame start landing in idle resets a pointer this edge; grant next cycle.
                if ((wr_req || rd_req) && !wr_frame_start && !rd_frame_start) begin
                    state_d     = StReq;
                    cmd_write_d = !grant_rd;
                    if (grant_rd) begin
                        cmd_addr_d = (rd_buf_q ? BUF1_BASE : Buf0Base) + rd_ptr;
                        wr_run_d   = 2'd0;
                    end else begin
                        cmd_addr_d = (wr_buf_q ? BUF1_BASE : Buf0Base) + wr_ptr;
                        wr_run_d   = (wr_run_q == 2'd2) ? 2'd2 : wr_run_q + 2'd1;
                    end
                end
            end
            StReq: begin
                if (cmd_ready) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (burst_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_buf_d    = wr_buf_q;
        rd_buf_d    = rd_buf_q;
        last_full_d = last_full_q;
        have_full_d = have_full_q;
        if (wr_swap) begin
            last_full_d = wr_buf_q;
            wr_buf_d    = !wr_buf_q;
            have_full_d = 1'b1;
        end
        // Uses the post-swap view so a simultaneous write swap is visible to the reader.
        if (rd_restart && have_full_d) begin
            rd_buf_d = last_full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            wr_run_q    <= 2'd0;
            wr_buf_q    <= 1'b0;
            rd_buf_q    <= 1'b1;
            last_full_q <= 1'b0;
            have_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            wr_run_q    <= wr_run_d;
            wr_buf_q    <= wr_buf_d;
            rd_buf_q    <= rd_buf_d;
            last_full_q <= last_full_d;
            have_full_q <= have_full_d;
        end
    end

    assign cmd_valid = (state_q == StReq);
    assign busy      = !in_idle;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign wr_buf    = wr_buf_q;
    assign rd_buf    = rd_buf_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter: reset/arbitration vector table, directed frame sequences and
// randomized bursts checked against a transaction-level model of the scheduling rules.
module tb_sdram_frame_arbiter;

    localparam int          BL = 256;
    localparam int          FW = 307200;
    localparam logic [23:0] B1 = 24'h080000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  wr_count = '0;
    logic [9:0]  rd_count = '0;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        burst_done = 1'b0;
    logic        cmd_valid, cmd_write, wr_buf, rd_buf, busy;
    logic [23:0] cmd_addr;

    sdram_frame_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_count       (wr_count),
        .rd_count       (rd_count),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .burst_done     (burst_done),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the scheduling rules, in whole-frame/word terms.
    int m_wr_ptr, m_rd_ptr, m_run;
    bit m_wr_buf, m_rd_buf, m_last_full, m_have_full;

    typedef struct {
        string       name;
        logic [9:0]  wc;
        logic [9:0]  rc;
        logic        vld;
        logic        wr;
        logic [23:0] addr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_wr_ptr = 0; m_rd_ptr = 0; m_run = 0;
        m_wr_buf = 1'b0; m_rd_buf = 1'b1; m_last_full = 1'b0; m_have_full = 1'b0;
    endtask

    task automatic model_start(input bit w, input bit r);
        if (w) begin
            if (m_wr_ptr == FW) begin
                m_last_full = m_wr_buf;
                m_wr_buf    = !m_wr_buf;
                m_have_full = 1'b1;
            end
            m_wr_ptr = 0;
        end
        if (r) begin
            if (m_have_full) m_rd_buf = m_last_full;
            m_rd_ptr = 0;
        end
    endtask

    // 1 = write expected, 0 = read expected, -1 = nothing should be issued.
    function automatic int pick();
        bit w_ok = (int'(wr_count) >= BL) && (m_wr_ptr < FW);
        bit r_ok = (int'(rd_count) <= 1023 - BL) && (m_rd_ptr < FW);
        if (r_ok && (!w_ok || m_run >= 2)) return 0;
        if (w_ok) return 1;
        return -1;
    endfunction

    function automatic logic [23:0] addr_of(input bit b, input int p);
        return (b ? B1 : 24'h0) + 24'(p);
    endfunction

    task automatic do_reset(input logic [9:0] wc, input logic [9:0] rc);
        rst_n = 1'b0;
        wr_count = wc;
        rd_count = rc;
        step(1);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic pulse_idle(input bit w, input bit r);
        wr_frame_start = w;
        rd_frame_start = r;
        step(1);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        model_start(w, r);
        check("buf_wr_after_start", 32'(wr_buf), 32'(m_wr_buf));
        check("buf_rd_after_start", 32'(rd_buf), 32'(m_rd_buf));
    endtask

    // Acts as the burst engine for one command; frame starts are injected in REQ or WAIT_DONE.
    task automatic serve(input int rdy_dly, input int done_dly, input bit inj_wr, input bit inj_rd,
                         input bit inj_req, input logic [9:0] nxt_wr, input logic [9:0] nxt_rd);
        int          exp_w;
        int          w;
        logic [23:0] exp_a;
        bit          in_req;
        exp_w  = pick();
        exp_a  = (exp_w == 1) ? addr_of(m_wr_buf, m_wr_ptr) : addr_of(m_rd_buf, m_rd_ptr);
        in_req = inj_req && (rdy_dly > 0);
        check("idle_gap_valid", 32'(cmd_valid), 32'(0));
        w = 0;
        while (cmd_valid !== 1'b1 && w < 8) begin
            step(1);
            w++;
        end
        check("issue_valid", 32'(cmd_valid), 32'(1));
        check("issue_write", 32'(cmd_write), 32'(exp_w == 1));
        check("issue_addr", 32'(cmd_addr), 32'(exp_a));
        check("issue_busy", 32'(busy), 32'(1));
        if (exp_w == 1) m_run++;
        else m_run = 0;
        for (int i = 0; i < rdy_dly; i++) begin
            if (in_req && i == 0) begin
                wr_frame_start = inj_wr;
                rd_frame_start = inj_rd;
            end
            step(1);
            wr_frame_start = 1'b0;
            rd_frame_start = 1'b0;
        end
        if (rdy_dly > 0) begin
            check("hold_valid", 32'(cmd_valid), 32'(1));
            check("hold_addr", 32'(cmd_addr), 32'(exp_a));
        end
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("handshake_valid_drop", 32'(cmd_valid), 32'(0));
        wr_count = nxt_wr;
        rd_count = nxt_rd;
        step(done_dly);
        if (!in_req && (inj_wr || inj_rd)) begin
            wr_frame_start = inj_wr;
            rd_frame_start = inj_rd;
            step(1);
            wr_frame_start = 1'b0;
            rd_frame_start = 1'b0;
        end
        check("wait_busy", 32'(busy), 32'(1));
        burst_done = 1'b1;
        step(1);
        burst_done = 1'b0;
        check("done_busy_fall", 32'(busy), 32'(0));
        if (exp_w == 1) m_wr_ptr += BL;
        else m_rd_ptr += BL;
        model_start(inj_wr, inj_rd);
        check("wr_buf", 32'(wr_buf), 32'(m_wr_buf));
        check("rd_buf", 32'(rd_buf), 32'(m_rd_buf));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset.
        do_reset(10'd0, 10'd1023);
        rst_n = 1'b0;
        step(1);
        check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
        check("rst_cmd_write", 32'(cmd_write), 32'(0));
        check("rst_cmd_addr", 32'(cmd_addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wr_buf", 32'(wr_buf), 32'(0));
        check("rst_rd_buf", 32'(rd_buf), 32'(1));

        // First arbitration out of reset, one cycle after the request is seen.
        vecs[0] = '{"none_low_full", 10'd0, 10'd1023, 1'b0, 1'b0, 24'h0};
        vecs[1] = '{"none_edges", 10'd255, 10'd768, 1'b0, 1'b0, 24'h0};
        vecs[2] = '{"wr_threshold", 10'd256, 10'd1023, 1'b1, 1'b1, 24'h0};
        vecs[3] = '{"rd_threshold", 10'd255, 10'd767, 1'b1, 1'b0, B1};
        vecs[4] = '{"wr_max", 10'd1023, 10'd800, 1'b1, 1'b1, 24'h0};
        vecs[5] = '{"rd_empty", 10'd0, 10'd0, 1'b1, 1'b0, B1};
        vecs[6] = '{"both_wr_wins", 10'd256, 10'd767, 1'b1, 1'b1, 24'h0};
        foreach (vecs[i]) begin
            do_reset(vecs[i].wc, vecs[i].rc);
            step(1);
            check({vecs[i].name, "_valid"}, 32'(cmd_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                check({vecs[i].name, "_write"}, 32'(cmd_write), 32'(vecs[i].wr));
                check({vecs[i].name, "_addr"}, 32'(cmd_addr), 32'(vecs[i].addr));
            end
        end

        // Contention: W, W, R, W, W, R with reads from buffer 1.
        do_reset(10'd300, 10'd0);
        for (int i = 0; i < 6; i++) serve(i % 2, 1, 1'b0, 1'b0, 1'b0, 10'd300, 10'd0);
        check("contention_rd_ptr", 32'(m_rd_ptr), 32'(2 * BL));

        // Write-only frame: 1200 bursts, then no more writes.
        do_reset(10'd256, 10'd1023);
        for (int i = 0; i < FW / BL; i++) serve(0, 0, 1'b0, 1'b0, 1'b0, 10'd256, 10'd1023);
        step(4);
        check("wr_done_stop", 32'(cmd_valid), 32'(0));

        // Swap: full frame + wr start -> wr_buf 1; rd start -> rd_buf 0, read at 0.
        wr_count = 10'd0;
        pulse_idle(1'b1, 1'b0);
        check("swap_wr_buf", 32'(wr_buf), 32'(1));
        pulse_idle(1'b0, 1'b1);
        check("swap_rd_buf", 32'(rd_buf), 32'(0));
        rd_count = 10'd0;
        check("swap_read_addr_model", 32'(addr_of(m_rd_buf, m_rd_ptr)), 32'(0));
        serve(0, 0, 1'b0, 1'b0, 1'b0, 10'd256, 10'd1023);

        // Fill buffer 1; frame start during the last WAIT_DONE swaps after the final advance.
        for (int i = 0; i < FW / BL; i++)
            serve(0, 1, (i == FW / BL - 1), 1'b0, 1'b0, 10'd256, 10'd1023);
        check("midburst_wr_buf", 32'(wr_buf), 32'(0));
        serve(1, 0, 1'b0, 1'b0, 1'b0, 10'd256, 10'd1023);

        // Partial frame: abandon at ptr 1024, no swap.
        for (int i = 0; i < 3; i++)
            serve(0, 0, 1'b0, 1'b0, 1'b0, (i == 2) ? 10'd0 : 10'd256, 10'd1023);
        check("partial_ptr_model", 32'(m_wr_ptr), 32'(1024));
        pulse_idle(1'b1, 1'b0);
        check("partial_wr_buf", 32'(wr_buf), 32'(0));
        wr_count = 10'd256;
        serve(0, 0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd1023);

        // Asynchronous reset while a command is pending.
        do_reset(10'd256, 10'd1023);
        step(1);
        check("pre_reset_valid", 32'(cmd_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(cmd_valid), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_wr_buf", 32'(wr_buf), 32'(0));
        check("async_rst_rd_buf", 32'(rd_buf), 32'(1));
        wr_count = 10'd0;
        step(1);
        rst_n = 1'b1;
        step(1);
        burst_done = 1'b1;
        step(1);
        burst_done = 1'b0;
        check("stray_done_busy", 32'(busy), 32'(0));
        wr_count = 10'd256;
        step(1);
        check("post_reset_valid", 32'(cmd_valid), 32'(1));
        check("post_reset_addr", 32'(cmd_addr), 32'(0));

        // Randomized bursts with random handshake delays and frame starts.
        do_reset(10'd512, 10'd100);
        for (int it = 0; it < 250; it++) begin
            if (pick() < 0) begin
                step(3);
                check("rand_no_request", 32'(cmd_valid), 32'(0));
                wr_count = 10'($urandom_range(0, 1023));
                rd_count = 10'($urandom_range(0, 1023));
            end else begin
                serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 1) == 1),
                      10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
